// File: rtl/sender_pkg.sv
// Shared definitions for the burst sender: FSM state encoding and default sizes.
package sender_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int DEPTH_DEF  = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    REQ     = 3'd2,
    RELEASE = 3'd3,
    FIN     = 3'd4
  } state_t;

endpackage

// File: rtl/sender_buffer_mem.sv
// Word buffer for the burst sender: synchronous write, registered read with
// one cycle of latency. The read register doubles as the outgoing data
// register, so it only loads when rd_en is high and otherwise holds its value.
module sender_buffer_mem
  import sender_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DEF,
  parameter  int DEPTH  = DEPTH_DEF,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage array: plain synchronous write, no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read; cleared by reset so the data output reads 0 after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/sender_burst_ctrl.sv
// Burst sender: buffers host words while idle, then on start drives them out
// in write order over a 4-phase Request/Ack handshake. Supports repeat mode
// (loop the buffer until abort), abort at a word boundary, and write-reject
// reporting.
module sender_burst_ctrl
  import sender_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DEF,
  parameter  int DEPTH  = DEPTH_DEF,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic [DATA_W-1:0] data,
  input  logic              write,
  input  logic              start,
  input  logic              repeat_mode,
  input  logic              abort,
  input  logic              Ack,
  output logic              Request,
  output logic [DATA_W-1:0] sdrDataOut,
  output logic              busy,
  output logic              done,
  output logic [AW:0]       level,
  output logic              full,
  output logic              empty,
  output logic              wr_err
);

  localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

  state_t        state;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   sent;
  logic          rep;
  logic          abort_pend;

  logic          wr_accept;
  logic          start_go;
  logic [AW:0]   sent_inc;
  logic [AW:0]   rd_inc;

  assign full      = (level == FULL_LEVEL);
  assign empty     = (level == '0);
  // Writes are only taken while idle; a simultaneous start loses to the write.
  assign wr_accept = write && (state == IDLE) && !full;
  assign start_go  = start && !write && (state == IDLE);
  assign sent_inc  = sent + 1'b1;
  assign rd_inc    = {1'b0, rd_ptr} + 1'b1;

  // The buffer's read register is the outgoing data register; it loads only in
  // FETCH, which keeps sdrDataOut stable for the whole handshake.
  sender_buffer_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_buf (
    .clk     (clk),
    .rst     (Reset),
    .wr_en   (wr_accept),
    .wr_addr (wr_ptr),
    .wr_data (data),
    .rd_en   (state == FETCH),
    .rd_addr (rd_ptr),
    .rd_data (sdrDataOut)
  );

  // Control FSM with registered outputs, pointers, counters and flags.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      sent       <= '0;
      level      <= '0;
      rep        <= 1'b0;
      abort_pend <= 1'b0;
      Request    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      wr_err     <= 1'b0;
    end else begin
      done   <= 1'b0;
      wr_err <= write && !wr_accept;

      if (wr_accept) begin
        wr_ptr <= wr_ptr + 1'b1;
        level  <= level + 1'b1;
      end

      // Abort is remembered until the next word boundary; ignored while idle.
      if (abort && (state != IDLE)) begin
        abort_pend <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (start_go) begin
            if (level == '0) begin
              // Nothing buffered: report completion without any handshake.
              done <= 1'b1;
            end else begin
              state  <= FETCH;
              busy   <= 1'b1;
              rep    <= repeat_mode;
              rd_ptr <= '0;
              sent   <= '0;
            end
          end
        end

        FETCH: begin
          Request <= 1'b1;
          state   <= REQ;
        end

        REQ: begin
          if (Ack) begin
            Request <= 1'b0;
            state   <= RELEASE;
          end
        end

        RELEASE: begin
          if (!Ack) begin
            sent <= sent_inc;
            if (abort_pend || abort) begin
              state <= FIN;
            end else if (rep) begin
              rd_ptr <= (rd_inc == level) ? '0 : rd_inc[AW-1:0];
              state  <= FETCH;
            end else if (sent_inc == level) begin
              state <= FIN;
            end else begin
              rd_ptr <= rd_inc[AW-1:0];
              state  <= FETCH;
            end
          end
        end

        FIN: begin
          done       <= 1'b1;
          busy       <= 1'b0;
          level      <= '0;
          wr_ptr     <= '0;
          rd_ptr     <= '0;
          sent       <= '0;
          abort_pend <= 1'b0;
          state      <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sender_burst_ctrl.sv
// Self-checking bench for sender_burst_ctrl: directed scenarios plus random
// bursts, checked against a queue-based model of the buffer contents.
module tb_sender_burst_ctrl;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 16;

  logic              clk = 1'b0;
  logic              Reset;
  logic [DATA_W-1:0] data;
  logic              write;
  logic              start;
  logic              repeat_mode;
  logic              abort;
  logic              Ack;
  logic              Request;
  logic [DATA_W-1:0] sdrDataOut;
  logic              busy;
  logic              done;
  logic [4:0]        level;
  logic              full;
  logic              empty;
  logic              wr_err;

  int vec  = 0;
  int errs = 0;

  // Model: words buffered in write order.
  logic [DATA_W-1:0] model_q[$];

  sender_burst_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .Reset       (Reset),
    .data        (data),
    .write       (write),
    .start       (start),
    .repeat_mode (repeat_mode),
    .abort       (abort),
    .Ack         (Ack),
    .Request     (Request),
    .sdrDataOut  (sdrDataOut),
    .busy        (busy),
    .done        (done),
    .level       (level),
    .full        (full),
    .empty       (empty),
    .wr_err      (wr_err)
  );

  always #5 clk = ~clk;

  // One host write; the model decides whether it should be rejected.
  task automatic write_word(input logic [DATA_W-1:0] d);
    logic exp_err;
    exp_err = (model_q.size() == DEPTH);
    if (!exp_err) model_q.push_back(d);
    data  = d;
    write = 1'b1;
    @(posedge clk); #1;
    write = 1'b0;
    vec++;
    if (wr_err !== exp_err) begin
      errs++; $display("FAIL write_err: got %b expected %b", wr_err, exp_err);
    end
    vec++;
    if (level !== 5'(model_q.size())) begin
      errs++; $display("FAIL write_level: got %0d expected %0d", level, model_q.size());
    end
    $display("write 0x%04h level=%0d wr_err=%b", d, level, wr_err);
  endtask

  // Start a burst from the model contents and act as the receiver.
  task automatic run_burst(input bit rep, input int abort_at, input int fixed_dly, input int busy_wr);
    logic [DATA_W-1:0] expq[$];
    logic [DATA_W-1:0] got[$];
    logic [DATA_W-1:0] cap;
    int cyc, since_low, dly, dly2, n;
    bit finished, req_prev;
    if (rep) begin
      for (int i = 0; i < abort_at; i++) expq.push_back(model_q[i % model_q.size()]);
    end else begin
      for (int i = 0; i < model_q.size(); i++)
        if (abort_at == 0 || i < abort_at) expq.push_back(model_q[i]);
    end
    repeat_mode = rep;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat_mode = 1'b0;
    vec++;
    if (busy !== 1'b1 || Request !== 1'b0) begin
      errs++; $display("FAIL start_state: busy=%b Request=%b expected busy=1 Request=0", busy, Request);
    end
    cyc = 1; since_low = -1; n = 0; dly = 0; dly2 = 0; cap = '0;
    finished = 1'b0; req_prev = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      cyc++;
      if (since_low >= 0) since_low++;
      abort = 1'b0;
      if (busy_wr >= 0 && c == busy_wr + 1) begin
        write = 1'b0;
        vec++;
        if (wr_err !== 1'b1) begin
          errs++; $display("FAIL busy_write_err: got %b expected 1", wr_err);
        end
      end
      if (busy_wr >= 0 && c == busy_wr) begin
        data  = DATA_W'($urandom);
        write = 1'b1;
      end
      if (done === 1'b1) begin
        finished = 1'b1;
        break;
      end
      if (Request === 1'b1 && req_prev == 1'b0) begin
        n++;
        cap = sdrDataOut;
        got.push_back(sdrDataOut);
        vec++;
        if ((n == 1) ? (cyc != 2) : (since_low != 2)) begin
          errs++; $display("FAIL req_latency: word %0d got %0d cycles expected 2", n, (n == 1) ? cyc : since_low);
        end
        since_low = -1;
        dly = (fixed_dly >= 0) ? fixed_dly : $urandom_range(0, 2);
        if (n == abort_at) abort = 1'b1;
      end
      if (Request === 1'b1 && Ack === 1'b0) begin
        if (dly == 0) begin
          vec++;
          if (sdrDataOut !== cap) begin
            errs++; $display("FAIL data_stable: got 0x%04h expected 0x%04h", sdrDataOut, cap);
          end
          Ack  = 1'b1;
          dly2 = (fixed_dly >= 0) ? fixed_dly : $urandom_range(0, 2);
        end else begin
          dly--;
        end
      end else if (Request === 1'b0 && Ack === 1'b1) begin
        if (dly2 == 0) begin
          Ack = 1'b0;
          since_low = 0;
        end else begin
          dly2--;
        end
      end
      req_prev = Request;
    end
    write = 1'b0;
    abort = 1'b0;
    Ack   = 1'b0;
    vec++;
    if (!finished) begin
      errs++; $display("FAIL burst_timeout: done never seen, expected done pulse");
    end
    vec++;
    if (got.size() != expq.size()) begin
      errs++; $display("FAIL burst_count: got %0d words expected %0d", got.size(), expq.size());
    end
    for (int i = 0; i < expq.size() && i < got.size(); i++) begin
      vec++;
      if (got[i] !== expq[i]) begin
        errs++; $display("FAIL burst_word[%0d]: got 0x%04h expected 0x%04h", i, got[i], expq[i]);
      end
    end
    vec++;
    if (busy !== 1'b0) begin
      errs++; $display("FAIL busy_at_done: got %b expected 0", busy);
    end
    @(posedge clk); #1;
    vec++;
    if (done !== 1'b0 || level !== 5'd0 || empty !== 1'b1 || Request !== 1'b0) begin
      errs++; $display("FAIL after_burst: done=%b level=%0d empty=%b Request=%b expected 0,0,1,0",
                       done, level, empty, Request);
    end
    $display("burst rep=%0b abort_at=%0d words_sent=%0d expected=%0d", rep, abort_at, got.size(), expq.size());
    model_q.delete();
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vec++;
    if (Request !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || wr_err !== 1'b0 || full !== 1'b0) begin
      errs++; $display("FAIL reset_flags: Request=%b busy=%b done=%b wr_err=%b full=%b expected all 0",
                       Request, busy, done, wr_err, full);
    end
    vec++;
    if (level !== 5'd0 || empty !== 1'b1 || sdrDataOut !== '0) begin
      errs++; $display("FAIL reset_level: level=%0d empty=%b data=0x%04h expected 0,1,0", level, empty, sdrDataOut);
    end
    Reset = 1'b0;
    @(posedge clk); #1;
    $display("reset released");
  endtask

  task automatic test_basic;
    write_word(16'h00A1);
    write_word(16'h00B2);
    write_word(16'h00C3);
    run_burst(1'b0, 0, 1, -1);
  endtask

  task automatic test_full;
    for (int i = 0; i < DEPTH; i++) write_word(DATA_W'($urandom));
    vec++;
    if (full !== 1'b1 || empty !== 1'b0) begin
      errs++; $display("FAIL full_flag: full=%b empty=%b expected 1,0", full, empty);
    end
    write_word(DATA_W'($urandom));
    run_burst(1'b0, 0, -1, -1);
  endtask

  task automatic test_empty_start;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    vec++;
    if (done !== 1'b1) begin
      errs++; $display("FAIL empty_done: got %b expected 1", done);
    end
    vec++;
    if (Request !== 1'b0 || busy !== 1'b0) begin
      errs++; $display("FAIL empty_req: Request=%b busy=%b expected 0,0", Request, busy);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      vec++;
      if (done !== 1'b0 || Request !== 1'b0) begin
        errs++; $display("FAIL empty_after: done=%b Request=%b expected 0,0", done, Request);
      end
    end
    $display("empty start handled");
  endtask

  task automatic test_repeat_abort;
    write_word(16'h0011);
    write_word(16'h0022);
    run_burst(1'b1, 3, -1, -1);
  endtask

  task automatic test_write_start;
    data  = 16'h5A5A;
    write = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    write = 1'b0;
    start = 1'b0;
    model_q.push_back(16'h5A5A);
    vec++;
    if (busy !== 1'b0 || level !== 5'd1 || wr_err !== 1'b0) begin
      errs++; $display("FAIL write_start: busy=%b level=%0d wr_err=%b expected 0,1,0", busy, level, wr_err);
    end
    run_burst(1'b0, 0, -1, -1);
  endtask

  task automatic test_reset_mid;
    bit seen;
    for (int i = 0; i < 3; i++) write_word(DATA_W'($urandom));
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (Request === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    vec++;
    if (!seen) begin
      errs++; $display("FAIL mid_req_timeout: Request never rose, expected 1");
    end
    #2 Reset = 1'b1;
    #1;
    vec++;
    if (Request !== 1'b0 || busy !== 1'b0 || level !== 5'd0 || empty !== 1'b1) begin
      errs++; $display("FAIL mid_reset: Request=%b busy=%b level=%0d empty=%b expected 0,0,0,1",
                       Request, busy, level, empty);
    end
    model_q.delete();
    @(posedge clk); #1;
    Reset = 1'b0;
    @(posedge clk); #1;
    $display("reset applied mid-burst");
    test_empty_start();
  endtask

  task automatic test_write_busy;
    for (int i = 0; i < 4; i++) write_word(DATA_W'($urandom));
    run_burst(1'b0, 0, -1, 0);
  endtask

  task automatic test_random;
    int n, ab;
    bit rep;
    for (int r = 0; r < 12; r++) begin
      n   = $urandom_range(1, DEPTH);
      rep = 1'($urandom_range(0, 1));
      for (int i = 0; i < n; i++) write_word(DATA_W'($urandom));
      if (rep) ab = $urandom_range(1, 2 * n + 2);
      else     ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, n) : 0;
      run_burst(rep, ab, -1, -1);
    end
  endtask

  initial begin
    Reset = 1'b1; data = '0; write = 1'b0; start = 1'b0;
    repeat_mode = 1'b0; abort = 1'b0; Ack = 1'b0;
    test_reset();
    test_basic();
    test_full();
    test_empty_start();
    test_repeat_abort();
    test_write_start();
    test_reset_mid();
    test_write_busy();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
